// File: rtl/lcd_scan_ctrl_pkg.sv
// lcd_scan_ctrl_pkg: shared state encoding and segment constants for the scan controller
package lcd_scan_ctrl_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_SCAN = 1'b1} state_t;
    localparam logic [6:0] SEG_OFF = 7'b0;
endpackage

// File: rtl/lcd.sv
// lcd: hex to seven-segment decoder, active-high segments
// b/f and c/e are swapped relative to the textbook map to match the board's mirrored digit wiring
module lcd (
    input  logic x3,
    input  logic x2,
    input  logic x1,
    input  logic x0,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic e,
    output logic f,
    output logic g
);
    logic [6:0] w_seg;
    always_comb begin
        case ({x3, x2, x1, x0})
            4'h0: w_seg = 7'h3F;
            4'h1: w_seg = 7'h30;
            4'h2: w_seg = 7'h6D;
            4'h3: w_seg = 7'h79;
            4'h4: w_seg = 7'h72;
            4'h5: w_seg = 7'h5B;
            4'h6: w_seg = 7'h5F;
            4'h7: w_seg = 7'h31;
            4'h8: w_seg = 7'h7F;
            4'h9: w_seg = 7'h7B;
            4'hA: w_seg = 7'h77;
            4'hB: w_seg = 7'h5E;
            4'hC: w_seg = 7'h0F;
            4'hD: w_seg = 7'h7C;
            4'hE: w_seg = 7'h4F;
            default: w_seg = 7'h47;
        endcase
    end
    assign {g, f, e, d, c, b, a} = w_seg;
endmodule

// File: rtl/lcd_scan_ctrl.sv
// lcd_scan_ctrl: time-multiplexed digit scanner sharing one lcd decoder
// New values wait in a pending register and are swapped in only at frame end, so frames never tear.
module lcd_scan_ctrl
    import lcd_scan_ctrl_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DWELL  = 4,
    parameter int LZS    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [4*DIGITS-1:0]   i_in_data,
    output logic [DIGITS-1:0]     o_dig_en_n,
    output logic [3:0]            o_nibble,
    output logic [6:0]            o_seg,
    output logic                  o_frame_done
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    state_t                r_state, w_state_nx;
    logic                  r_pend, w_pend_nx;
    logic [4*DIGITS-1:0]   r_pend_data, w_pend_data_nx;
    logic [4*DIGITS-1:0]   r_active, w_active_nx;
    logic [IW-1:0]         r_idx, w_idx_nx;
    logic [CW-1:0]         r_cnt, w_cnt_nx;
    logic                  w_cnt_end, w_frame_end, w_blank;
    logic [4*DIGITS-1:0]   w_sh;
    logic [6:0]            w_seg;

    assign w_cnt_end   = r_cnt == CW'(DWELL - 1);
    assign w_frame_end = (r_state == ST_SCAN) && w_cnt_end && (r_idx == IW'(DIGITS - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_pend      <= 1'b0;
            r_pend_data <= '0;
            r_active    <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_pend      <= w_pend_nx;
            r_pend_data <= w_pend_data_nx;
            r_active    <= w_active_nx;
            r_idx       <= w_idx_nx;
            r_cnt       <= w_cnt_nx;
        end
    end

    // in_ready is !pend, so a transfer and a swap never both touch pend on one edge
    always_comb begin
        w_state_nx     = r_state;
        w_pend_nx      = r_pend;
        w_pend_data_nx = r_pend_data;
        w_active_nx    = r_active;
        w_idx_nx       = r_idx;
        w_cnt_nx       = r_cnt;
        if (i_in_valid && !r_pend) begin
            w_pend_nx      = 1'b1;
            w_pend_data_nx = i_in_data;
        end
        if (r_state == ST_IDLE) begin
            if (r_pend) begin
                w_active_nx = r_pend_data;
                w_pend_nx   = 1'b0;
                w_idx_nx    = '0;
                w_cnt_nx    = '0;
                w_state_nx  = ST_SCAN;
            end
        end else begin
            w_cnt_nx = w_cnt_end ? '0 : r_cnt + 1'b1;
            if (w_cnt_end)
                w_idx_nx = (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
            if (w_frame_end && r_pend) begin
                w_active_nx = r_pend_data;
                w_pend_nx   = 1'b0;
            end
        end
    end

    // nibbles idx..DIGITS-1 all zero means this digit is a leading zero
    assign w_sh    = r_active >> {r_idx, 2'b00};
    assign w_blank = (r_state == ST_IDLE) || ((LZS != 0) && (r_idx != '0) && (w_sh == '0));

    lcd u_lcd (
        .x3(o_nibble[3]), .x2(o_nibble[2]), .x1(o_nibble[1]), .x0(o_nibble[0]),
        .a(w_seg[0]), .b(w_seg[1]), .c(w_seg[2]), .d(w_seg[3]),
        .e(w_seg[4]), .f(w_seg[5]), .g(w_seg[6])
    );

    assign o_nibble     = w_sh[3:0];
    assign o_dig_en_n   = w_blank ? '1 : ~(DIGITS'(1) << r_idx);
    assign o_seg        = w_blank ? SEG_OFF : w_seg;
    assign o_frame_done = w_frame_end;
    assign o_in_ready   = !r_pend;
endmodule

// File: tb/tb_lcd_scan_ctrl.sv
// tb_lcd_scan_ctrl: directed vector bench for lcd_scan_ctrl (DIGITS=4, DWELL=2; LZS=1 and LZS=0 instances)
module tb_lcd_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        rdy0, rdy1, fd0, fd1;
    logic [3:0]  dig0, dig1, nib0, nib1;
    logic [6:0]  seg0, seg1;
    int          tests = 0;
    int          failed = 0;

    always #5 clk = ~clk;

    lcd_scan_ctrl #(.DIGITS(4), .DWELL(2), .LZS(1)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(rdy0),
        .i_in_data(in_data), .o_dig_en_n(dig0), .o_nibble(nib0), .o_seg(seg0),
        .o_frame_done(fd0)
    );

    lcd_scan_ctrl #(.DIGITS(4), .DWELL(2), .LZS(0)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(rdy1),
        .i_in_data(in_data), .o_dig_en_n(dig1), .o_nibble(nib1), .o_seg(seg1),
        .o_frame_done(fd1)
    );

    typedef struct {
        logic        rst_n;
        logic        valid;
        logic [15:0] data;
        logic [3:0]  dig;
        logic [3:0]  nib;
        logic [6:0]  seg;
        logic        rdy;
        logic        fd;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input int cyc, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s @%0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    logic [3:0] b_nib[12];
    logic [3:0] b_dig[12];
    logic [3:0] c_dig[8];

    initial begin
        // reset, idle, then load 0001 and watch a full frame plus one digit
        vecs[0]  = '{1'b0, 1'b0, 16'h0000, 4'b1111, 4'h0, 7'b0000000, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 16'h0042, 4'b1111, 4'h0, 7'b0000000, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 16'h0000, 4'b1111, 4'h0, 7'b0000000, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 16'h0001, 4'b1111, 4'h0, 7'b0000000, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 16'h0000, 4'b1110, 4'h1, 7'b0110000, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 16'h0000, 4'b1110, 4'h1, 7'b0110000, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 16'h0000, 4'b1111, 4'h0, 7'b0000000, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 16'h0000, 4'b1111, 4'h0, 7'b0000000, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 16'h0000, 4'b1111, 4'h0, 7'b0000000, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 16'h0000, 4'b1111, 4'h0, 7'b0000000, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 16'h0000, 4'b1111, 4'h0, 7'b0000000, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 16'h0000, 4'b1111, 4'h0, 7'b0000000, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 16'h0000, 4'b1110, 4'h1, 7'b0110000, 1'b1, 1'b0};
        // 1000 frame finishing, then 2345 from idx 0 with in_valid still held
        b_nib = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h5, 4'h5, 4'h4, 4'h4, 4'h3, 4'h3};
        b_dig = '{4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111,
                  4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011};
        c_dig = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111};

        for (int i = 0; i < 13; i++) begin
            rst_n = vecs[i].rst_n;
            in_valid = vecs[i].valid;
            in_data = vecs[i].data;
            step();
            chk("a_dig", i, 16'(dig0), 16'(vecs[i].dig));
            chk("a_nib", i, 16'(nib0), 16'(vecs[i].nib));
            chk("a_seg", i, 16'(seg0), 16'(vecs[i].seg));
            chk("a_rdy", i, 16'(rdy0), 16'(vecs[i].rdy));
            chk("a_fd",  i, 16'(fd0),  16'(vecs[i].fd));
        end

        // swap only at the frame-end edge; held in_valid transfers one cycle later
        do_reset();
        in_valid = 1'b1;
        in_data = 16'h1000;
        step();
        in_valid = 1'b0;
        step();
        chk("b_load_dig", 0, 16'(dig0), 16'(4'b1110));
        chk("b_load_seg", 0, 16'(seg0), 16'(7'b0111111));
        in_valid = 1'b1;
        in_data = 16'h2345;
        step();
        chk("b_xfer_rdy", 1, 16'(rdy0), 16'(1'b0));
        chk("b_xfer_nib", 1, 16'(nib0), 16'(4'h0));
        for (int k = 0; k < 12; k++) begin
            step();
            chk("b_nib", k + 2, 16'(nib0), 16'(b_nib[k]));
            chk("b_dig", k + 2, 16'(dig0), 16'(b_dig[k]));
            chk("b_rdy", k + 2, 16'(rdy0), 16'(k == 6));
            chk("b_fd",  k + 2, 16'(fd0),  16'(k == 5));
        end
        in_valid = 1'b0;

        // zero value: LZS=0 shows every digit, LZS=1 only digit 0
        do_reset();
        in_valid = 1'b1;
        in_data = 16'h0000;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("c_dig1", k, 16'(dig1), 16'(c_dig[k]));
            chk("c_seg1", k, 16'(seg1), 16'(7'b0111111));
            chk("c_dig0", k, 16'(dig0), (k < 2) ? 16'(4'b1110) : 16'(4'b1111));
        end

        // reset while scanning with data pending discards it
        in_valid = 1'b1;
        in_data = 16'h0001;
        step();
        chk("d_pend_rdy", 0, 16'(rdy0), 16'(1'b0));
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("d_rst_dig", 0, 16'(dig0), 16'(4'b1111));
        chk("d_rst_rdy", 0, 16'(rdy0), 16'(1'b1));
        chk("d_rst_seg", 0, 16'(seg0), 16'(7'b0));
        for (int k = 0; k < 10; k++) begin
            step();
            chk("d_dark_dig", k, 16'(dig0), 16'(4'b1111));
            chk("d_dark_fd",  k, 16'(fd0),  16'(1'b0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/lcd_scan_ctrl.md
# lcd_scan_ctrl

Time-multiplexed scan controller that shares one `lcd` hex-to-seven-segment decoder across `DIGITS` common-anode digit positions. It accepts a packed multi-digit value through a valid/ready handshake and holds it in a pending register. It swaps that value into the displayed register only at a frame boundary, so the display never tears. Each digit in turn is driven for `DWELL` cycles, with optional leading-zero suppression. The block sits between the board-level display pins and any producer of a displayable value, such as a counter or temperature readout.

## Interface
- `DIGITS`, 4: number of digit positions, 1..8; digit 0 is least significant.
- `DWELL`, 4: cycles each digit is enabled, ≥1.
- `LZS`, 1: 1 = blank leading zero digits; 0 = show all digits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: producer offers `in_data`.
- `in_ready` out 1: controller can accept; equals `!pend`.
- `in_data` in 4*DIGITS: packed nibbles; `in_data[4i+3:4i]` is digit i.
- `dig_en_n` out DIGITS: one-cold digit enable; all ones = display dark.
- `nibble` out 4: value currently fed to the decoder.
- `seg` out 7: `{g,f,e,d,c,b,a}` from the `lcd` instance; forced to 0 when blanked.
- `frame_done` out 1: high in the last cycle of every scan frame.

## Operation
- Registers:
  - `state` ∈ {IDLE, SCAN}
  - `pend` (1b) and `pend_data` (4·DIGITS)
  - `active` (4·DIGITS)
  - `idx` (⌈log2 DIGITS⌉, min 1)
  - `cnt` (⌈log2 DWELL⌉, min 1)
- Reset values: `state`=IDLE, `pend`=0, `pend_data`=0, `active`=0, `idx`=0, `cnt`=0.
  - Resulting outputs: `dig_en_n`=all ones, `nibble`=0, `seg`=0, `frame_done`=0, `in_ready`=1.
- Handshake:
  - A transfer occurs on any edge where `in_valid && in_ready`; then `pend_data`←`in_data` and `pend`←1.
  - `in_valid` may drop without a transfer; no state changes.
- IDLE:
  - If `pend`=1 on an edge: `active`←`pend_data`, `pend`←0, `idx`←0, `cnt`←0, `state`←SCAN.
  - Otherwise stay in IDLE with the display dark.
- SCAN:
  - `cnt` increments each cycle. At `cnt`=DWELL-1, `cnt`←0 and `idx` advances.
  - At `idx`=DIGITS-1 with `cnt`=DWELL-1 (frame end), `idx` wraps to 0 and `frame_done`=1 in that cycle.
  - On the frame-end edge, if `pend`=1: `active`←`pend_data` and `pend`←0.
  - SCAN never returns to IDLE except through reset.
- Outputs (combinational from registers):
  - `nibble`=`active[4·idx+3:4·idx]`.
  - `dig_en_n`=~(1<<idx) unless blanked.
  - `seg`=lcd(`nibble`) unless blanked.
- Blanking applies in IDLE, or when `LZS`=1, idx>0, and every nibble of `active` from idx through DIGITS-1 is 0.
  - Blanking forces `dig_en_n`=all ones and `seg`=0.
  - Digit 0 is never suppressed, so the value 0 shows as a single "0".
- Simultaneous events: because `in_ready`=`!pend`, a transfer and a frame-end swap cannot both write `pend` on the same edge. A producer waiting on `in_ready` transfers no earlier than the cycle after the swap.
- Reset mid-frame or with data pending: everything returns to reset values, and pending data is discarded.
- `DIGITS`=1: `idx` stays 0 and every DWELL-th cycle is a frame end.

## Timing
- Transfer at edge t: `pend`=1 after t. From IDLE, `active` is loaded and SCAN starts after edge t+1, and digit 0 is visible in cycle t+1…t+2. `in_ready` is high again after t+1.
- The frame length is exactly DIGITS·DWELL cycles; each digit is enabled for exactly DWELL consecutive cycles.
- Swap latency from a transfer during SCAN is at most one frame plus one cycle.
- The decoder path is purely combinational; no output has register latency relative to `idx`/`active`.

## Structure
- Shared package: state encoding (`ST_IDLE`=0, `ST_SCAN`=1) and the `SEG_OFF`=7'b0 constant.
- One sub-module: the existing `lcd` decoder, instantiated once with x3..x0 = `nibble` and outputs concatenated into `seg`.
- Counter widths are derived locally from the parameters with `$clog2`.

## Test plan (DIGITS=4, DWELL=2, LZS=1 unless noted)
- Reset hold, no input → `dig_en_n`=4'b1111, `seg`=0, `in_ready`=1, and `frame_done` never asserts.
- Load 16'h0001 → digit 0 shows `seg`=7'b0110000 with `dig_en_n`=4'b1110 for 2 cycles; digits 1–3 stay dark; `frame_done` pulses every 8 cycles.
- Load 16'h1000, then load 16'h2345 mid-frame → `in_ready`=0 until the frame-end edge; 16'h1000 completes its frame untorn; 16'h2345 appears starting at idx 0.
- LZS=0, load 16'h0000 → all four digits show `seg`=7'b0111111 in turn, enables cycling 1110→1101→1011→0111.
- Hold `in_valid`=1 across a swap → a second transfer occurs exactly one cycle after the frame-end edge, never on it.
- Assert `rst_n`=0 in SCAN with `pend`=1 → the next cycle is dark with `in_ready`=1, and the pending value never displays.
